// File: rtl/mod_counter_pkg.sv
// mod_counter shared constants.
// Mode and direction encodings used by the counter and its next-value logic.
package mod_counter_pkg;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/mod_counter_next.sv
// mod_counter next-value logic.
// Pure combinational: step value, terminal count, bound event, load clamp.
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 255,
  parameter bit          SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             up,
  input  logic             count,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc,
  output logic             bound,
  output logic [WIDTH-1:0] step_val,
  output logic [WIDTH-1:0] load_clamp
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  always_comb begin
    tc       = 1'b0;
    step_val = cur;
    unique case (up)
      DIR_UP: begin
        tc = (cur == MAXV);
        if (!tc)
          step_val = cur + 1'b1;
        else if (SATURATE == MODE_WRAP)
          step_val = '0;
      end
      DIR_DOWN: begin
        tc = (cur == '0);
        if (!tc)
          step_val = cur - 1'b1;
        else if (SATURATE == MODE_WRAP)
          step_val = MAXV;
      end
      default: ;
    endcase
  end

  assign bound = count & tc;

  assign load_clamp = (load_val > MAXV) ? MAXV : load_val;

endmodule

// File: rtl/mod_counter.sv
// mod_counter: up/down modulo counter with wrap/saturate modes.
// Registers and priority muxing only; arithmetic lives in mod_counter_next.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 255,
  parameter bit          SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             count,
  input  logic             up,
  output logic [WIDTH-1:0] counter_out,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             ovf
);

  if (WIDTH < 2 || WIDTH > 32 || MAX_VAL == 0 ||
      64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_param_err
    $error("mod_counter: MAX_VAL/WIDTH combination out of range");
  end

  logic             bound;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamp;

  mod_counter_next #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_next (
    .cur        (counter_out),
    .up         (up),
    .count      (count),
    .load_val   (load_val),
    .tc         (tc),
    .bound      (bound),
    .step_val   (step_val),
    .load_clamp (load_clamp)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      counter_out <= '0;
      wrap_pulse  <= 1'b0;
      ovf         <= 1'b0;
    end else if (clr) begin
      counter_out <= '0;
      wrap_pulse  <= 1'b0;
      ovf         <= 1'b0;
    end else if (load) begin
      counter_out <= load_clamp;
      wrap_pulse  <= 1'b0;
    end else if (count) begin
      counter_out <= step_val;
      wrap_pulse  <= bound;
      ovf         <= ovf | bound;
    end else begin
      wrap_pulse  <= 1'b0;
    end
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, counter bit width (legal range 2..32).
REQ-002 The block SHALL have parameter MAX_VAL, default 255, the counter's upper bound (legal range 1..2**WIDTH-1).
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 = wrap at bounds, 1 = hold at bounds.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port clr  input  1  synchronous clear of count and flags.
REQ-007 The block SHALL have port load  input  1  synchronous load of load_val.
REQ-008 The block SHALL have port load_val  input  WIDTH  value to load.
REQ-009 The block SHALL have port count  input  1  count enable.
REQ-010 The block SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-011 The block SHALL have port counter_out  output  WIDTH  registered count value.
REQ-012 The block SHALL have port tc  output  1  terminal count, combinational: counter_out==MAX_VAL when up=1, counter_out==0 when up=0.
REQ-013 The block SHALL have port wrap_pulse  output  1  registered, high for exactly one cycle after a bound event.
REQ-014 The block SHALL have port ovf  output  1  registered sticky flag, set by any bound event.

Function
REQ-015 Per-edge priority SHALL be: rst low > clr > load > count > hold.
REQ-016 load SHALL set counter_out to min(load_val, MAX_VAL) on the next edge, with no bound event generated.
REQ-017 count=1, up=1, counter_out<MAX_VAL SHALL increment counter_out by 1 on the next edge.
REQ-018 count=1, up=0, counter_out>0 SHALL decrement counter_out by 1 on the next edge.
REQ-019 A bound event is count=1 with tc=1 (and no clr or load), which SHALL yield next value 0 (up) or MAX_VAL (down) when SATURATE=0, or an unchanged value when SATURATE=1.
REQ-020 wrap_pulse SHALL be 1 in the cycle after each bound event and 0 otherwise; back-to-back bound events SHALL keep it high on consecutive cycles.
REQ-021 ovf SHALL be set by a bound event, stay set, and clear only on clr or reset.
REQ-022 count=0 with no clr and no load SHALL hold all registers; wrap_pulse SHALL return to 0.
REQ-023 Arithmetic SHALL be performed modulo MAX_VAL+1; counter_out SHALL never exceed MAX_VAL.
REQ-024 A change of up while holding SHALL take effect on the next counting edge without a glitch on counter_out.
REQ-025 Simultaneous clr and load SHALL clear (clr wins); simultaneous load and count SHALL load (count ignored).

Reset
REQ-026 At a rising clk edge with rst=0, counter_out SHALL become 0, wrap_pulse 0 and ovf 0, regardless of other inputs.
REQ-027 Reset asserted mid-count SHALL abort the count; the first edge with rst=1 SHALL resume normal operation from 0.
REQ-028 No asynchronous reset path SHALL exist.

Structure
REQ-029 A shared package SHALL hold the SATURATE mode constants (MODE_WRAP=0, MODE_SAT=1) and the direction constants (DIR_UP=1, DIR_DOWN=0).
REQ-030 Next-value and bound-event logic SHALL be a combinational sub-module, mod_counter_next; mod_counter SHALL hold only registers and priority muxing.
REQ-031 Illegal parameter combinations (MAX_VAL > 2**WIDTH-1) SHALL be flagged at elaboration.

Verification
REQ-032 Reset: WIDTH=8, count=1 for 10 cycles, then rst=0 for 1 edge -> counter_out=0, ovf=0, wrap_pulse=0.
REQ-033 Wrap up: MAX_VAL=9, SATURATE=0, load 8, count=1 up=1 for 3 edges -> 9, 0, 1; wrap_pulse high only after the 9->0 edge; ovf=1.
REQ-034 Saturate down: SATURATE=1, load 1, count=1 up=0 for 3 edges -> 0, 0, 0; tc=1 from the first 0; wrap_pulse high on 2 consecutive cycles.
REQ-035 Load clamp and priority: MAX_VAL=9, load_val=15 load=1 count=1 -> 9; then clr=1 load=1 -> 0 and ovf=0.
REQ-036 Width sweep: WIDTH=4, MAX_VAL=15, up for 40 edges -> sequence matches modulo-16 model, ovf set after the 16th edge.
